fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- First stage of the 5-stage MIPS pipeline.
- Owns the PC and issues instruction reads to the icache.
- Holds the fetch/decode pipeline latch that feeds the decode stage with instruction and next-PC.
- Applies stall, redirect (branch/jump) and halt, and keeps the icache address stable across misses, including a redirect that arrives mid-miss.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset
WORD_W, 32, instruction and address width

Ports:
CLK  in  1  pipeline clock
RST  in  1  reset: asynchronous, active-high
iREN  out  1  icache read request
iaddr  out  WORD_W  icache read address
ihit  in  1  icache response valid this cycle
iload  in  WORD_W  instruction returned by the icache
stall  in  1  hazard unit: decode cannot accept; hold the latch
redirect  in  1  branch/jump resolved taken; flush and retarget
redirect_pc  in  WORD_W  redirect target
halt  in  1  decode stage has a halt opcode in its latch
fd_valid  out  1  latch holds a live instruction
fd_instr  out  WORD_W  latched instruction
fd_npc  out  WORD_W  latched PC+4

Behaviour:
- RST is asynchronous and active-high, applied at any time. It sets:
  - pc=PC_INIT, state=FETCH
  - pend_pc=0, halt_pend=0
  - fd_valid=0, fd_instr=0, fd_npc=0
- While RST is high, iREN=0.
- States are FETCH, DRAIN and HALTED, held in fetch_state_t.
- iREN=1 in FETCH and DRAIN; iREN=0 in HALTED.
- iaddr=pc in every state.
- pc updates only on an ihit cycle or on a redirect taken in FETCH with ihit. This keeps iaddr stable until the icache answers.
- FETCH, priority redirect > halt > stall > normal:
  - redirect & ihit: pc<=redirect_pc with bits[1:0] forced to 0; latch flushed (fd_valid<=0, fd_instr<=0, fd_npc<=0).
  - redirect & !ihit: pend_pc<=redirect_pc with bits[1:0] forced to 0; latch flushed; go to DRAIN.
  - halt & ihit: latch flushed; go to HALTED.
  - halt & !ihit: halt_pend<=1; latch flushed; go to DRAIN.
  - stall: latch and pc hold; an ihit this cycle is discarded and re-fetched later.
  - ihit & !stall: fd_instr<=iload, fd_npc<=pc+4, fd_valid<=1, pc<=pc+4. Addition wraps mod 2^32: 32'hFFFF_FFFC goes to 0.
  - !ihit & !stall: bubble; fd_valid<=0, fd_instr<=0, other fields hold.
- DRAIN (an in-flight miss for the old pc must complete):
  - Latch stays flushed.
  - stall is ignored.
  - A new redirect overwrites pend_pc (latest wins) and clears halt_pend.
  - A new halt sets halt_pend.
  - On ihit, iload is discarded. Then go to HALTED if halt_pend, else pc<=pend_pc and go to FETCH.
  - A redirect in the same cycle as ihit uses the new target.
- HALTED:
  - Sticky until RST.
  - pc and latch hold, fd_valid=0.
  - redirect, stall and ihit are ignored.
- Latency:
  - Icache hit: instruction visible on fd_* one cycle after the ihit edge.
  - Redirect taken with ihit: first target instruction is requested the following cycle.

Decomposition:
- Shared cpu_types_pkg carries word_t (existing), the fetch_state_t enum (FETCH, DRAIN, HALTED) and the PC_STEP constant (4).
- Single module; no sub-module. PC and latch logic are too small to split.

Test Plan:
- Reset then ihit tied 1 and iload=instruction at 0x0,0x4,0x8 -> iaddr 0x0,0x4,0x8 on successive cycles; fd_npc 0x4,0x8,0xC; fd_valid=1 from cycle 1.
- ihit low 3 cycles at pc=0x10 -> iaddr held at 0x10 and fd_valid=0 for 3 cycles; on ihit, fd_instr=iload and fd_npc=0x14.
- stall high 2 cycles with ihit=1 at pc=0x20 -> fd_* and pc unchanged for 2 cycles; after release fd_npc=0x24.
- redirect=1, redirect_pc=0x103 during a miss at pc=0x40 -> DRAIN; iaddr stays 0x40 until ihit; that iload is dropped; next iaddr=0x100; fd_valid=0 throughout.
- Second redirect to 0x200 while in DRAIN, then ihit -> next iaddr=0x200, not the first target.
- halt with ihit -> HALTED; iREN=0 and fd_valid=0 forever; RST asserted mid-halt -> pc=PC_INIT and iREN=1 after RST drops.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types.
//   word_t        : 32-bit machine word (instructions, addresses)
//   fetch_state_t : fetch-stage control states
//   PC_STEP       : byte distance between sequential instructions
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_stage.sv
// Fetch stage of the 5-stage MIPS pipeline: owns the PC, issues icache reads
// and holds the fetch/decode latch.
//
// Ports:
//   CLK, RST           pipeline clock, async active-high reset
//   iREN, iaddr        icache read request / address (iaddr is always pc)
//   ihit, iload        icache response valid / returned instruction
//   stall              decode cannot accept: hold latch and pc
//   redirect(_pc)      taken branch/jump: flush and retarget
//   halt               decode holds a halt opcode
//   fd_valid/instr/npc fetch/decode latch contents
//
// state  | meaning
// -------+-------------------------------------------------------------
// FETCH  | normal fetch; latch loads on ihit unless stalled
// DRAIN  | waiting for an in-flight miss to land before retarget/halt
// HALTED | sticky stop until RST; no icache requests
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter int               WORD_W  = 32,
    parameter logic [WORD_W-1:0] PC_INIT = '0
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic              ihit,
    input  logic [WORD_W-1:0] iload,
    input  logic              stall,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              fd_valid,
    output logic [WORD_W-1:0] fd_instr,
    output logic [WORD_W-1:0] fd_npc
);

    fetch_state_t      state, state_n;
    logic [WORD_W-1:0] pc, pc_n;
    logic [WORD_W-1:0] pend_pc, pend_pc_n;
    logic              halt_pend, halt_pend_n;
    logic              fd_valid_n;
    logic [WORD_W-1:0] fd_instr_n, fd_npc_n;

    logic [WORD_W-1:0] pc_inc;
    logic [WORD_W-1:0] tgt;
    logic              halt_now;

    assign pc_inc = pc + WORD_W'(PC_STEP);
    assign tgt    = {redirect_pc[WORD_W-1:2], 2'b00};

    // In DRAIN a same-cycle redirect cancels any pending halt; a same-cycle
    // halt (without redirect) counts as already pending.
    assign halt_now = redirect ? 1'b0 : (halt | halt_pend);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= FETCH;
            pc        <= PC_INIT;
            pend_pc   <= '0;
            halt_pend <= 1'b0;
            fd_valid  <= 1'b0;
            fd_instr  <= '0;
            fd_npc    <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            pend_pc   <= pend_pc_n;
            halt_pend <= halt_pend_n;
            fd_valid  <= fd_valid_n;
            fd_instr  <= fd_instr_n;
            fd_npc    <= fd_npc_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        pend_pc_n   = pend_pc;
        halt_pend_n = halt_pend;
        fd_valid_n  = fd_valid;
        fd_instr_n  = fd_instr;
        fd_npc_n    = fd_npc;

        case (state)
            FETCH: begin
                if (redirect) begin
                    fd_valid_n = 1'b0;
                    fd_instr_n = '0;
                    fd_npc_n   = '0;
                    if (ihit) begin
                        pc_n = tgt;
                    end else begin
                        // Miss in flight for the old pc: park the target.
                        pend_pc_n = tgt;
                        state_n   = DRAIN;
                    end
                end else if (halt) begin
                    fd_valid_n = 1'b0;
                    fd_instr_n = '0;
                    fd_npc_n   = '0;
                    if (ihit) begin
                        state_n = HALTED;
                    end else begin
                        halt_pend_n = 1'b1;
                        state_n     = DRAIN;
                    end
                end else if (stall) begin
                    // Hold everything; an ihit here is dropped and re-fetched.
                end else if (ihit) begin
                    fd_valid_n = 1'b1;
                    fd_instr_n = iload;
                    fd_npc_n   = pc_inc;
                    pc_n       = pc_inc;
                end else begin
                    fd_valid_n = 1'b0;
                    fd_instr_n = '0;
                end
            end

            DRAIN: begin
                fd_valid_n = 1'b0;
                fd_instr_n = '0;
                fd_npc_n   = '0;
                if (redirect) begin
                    pend_pc_n   = tgt;
                    halt_pend_n = 1'b0;
                end else if (halt) begin
                    halt_pend_n = 1'b1;
                end
                if (ihit) begin
                    if (halt_now) begin
                        state_n = HALTED;
                    end else begin
                        pc_n    = redirect ? tgt : pend_pc;
                        state_n = FETCH;
                    end
                end
            end

            HALTED: begin
                fd_valid_n = 1'b0;
            end

            default: begin
                state_n = FETCH;
            end
        endcase
    end

    assign iaddr = pc;
    assign iREN  = ~RST & (state != HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import cpu_types_pkg::*;

    localparam logic [31:0] PC_INIT = 32'h0000_0000;
    localparam int MF = 0;   // model: fetching
    localparam int MD = 1;   // model: waiting for miss to land
    localparam int MH = 2;   // model: halted

    logic  CLK = 1'b0;
    logic  RST = 1'b1;
    logic  iREN;
    word_t iaddr;
    logic  ihit = 1'b0;
    word_t iload = '0;
    logic  stall = 1'b0;
    logic  redirect = 1'b0;
    word_t redirect_pc = '0;
    logic  halt = 1'b0;
    logic  fd_valid;
    word_t fd_instr;
    word_t fd_npc;

    int checks = 0;
    int errors = 0;

    // reference model state
    int    m_mode;
    word_t m_pc, m_pend, m_i, m_n;
    logic  m_hp, m_v;

    fetch_stage #(.WORD_W(32), .PC_INIT(PC_INIT)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .ihit(ihit),
        .iload(iload), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .fd_valid(fd_valid),
        .fd_instr(fd_instr), .fd_npc(fd_npc)
    );

    always #5 CLK = ~CLK;

    function automatic word_t instr_at(input word_t a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = MF; m_pc = PC_INIT; m_pend = '0; m_hp = 1'b0;
        m_v = 1'b0; m_i = '0; m_n = '0;
    endtask

    task automatic model_flush();
        m_v = 1'b0; m_i = '0; m_n = '0;
    endtask

    task automatic model_step(input logic h, input word_t ld, input logic s,
                              input logic r, input word_t rp, input logic hl);
        word_t t;
        t = rp & 32'hFFFF_FFFC;
        if (m_mode == MF) begin
            if (r) begin
                model_flush();
                if (h) m_pc = t;
                else begin m_pend = t; m_mode = MD; end
            end else if (hl) begin
                model_flush();
                if (h) m_mode = MH;
                else begin m_hp = 1'b1; m_mode = MD; end
            end else if (s) begin
                // everything held
            end else if (h) begin
                m_v = 1'b1; m_i = ld; m_n = m_pc + 32'd4; m_pc = m_pc + 32'd4;
            end else begin
                m_v = 1'b0; m_i = '0;
            end
        end else if (m_mode == MD) begin
            model_flush();
            if (r) begin m_pend = t; m_hp = 1'b0; end
            else if (hl) m_hp = 1'b1;
            if (h) begin
                if (m_hp) m_mode = MH;
                else begin m_pc = m_pend; m_mode = MF; end
            end
        end
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input logic h, input word_t ld, input logic s,
                        input logic r, input word_t rp, input logic hl);
        ihit = h; iload = ld; stall = s; redirect = r; redirect_pc = rp; halt = hl;
        #1;
        check("iaddr_pre", iaddr, m_pc);
        check("iren_pre", 32'(iREN), 32'(m_mode != MH));
        @(posedge CLK); #1;
        model_step(h, ld, s, r, rp, hl);
        check("fd_valid", 32'(fd_valid), 32'(m_v));
        check("fd_instr", fd_instr, m_i);
        check("fd_npc", fd_npc, m_n);
        check("iaddr", iaddr, m_pc);
        check("iren", 32'(iREN), 32'(m_mode != MH));
    endtask

    task automatic do_reset();
        ihit = 0; iload = '0; stall = 0; redirect = 0; redirect_pc = '0; halt = 0;
        #2 RST = 1'b1;
        #1;
        model_reset();
        check("rst_iren", 32'(iREN), 32'd0);
        check("rst_valid", 32'(fd_valid), 32'd0);
        check("rst_instr", fd_instr, 32'd0);
        check("rst_npc", fd_npc, 32'd0);
        check("rst_iaddr", iaddr, PC_INIT);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;
        model_step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        check("post_rst_iren", 32'(iREN), 32'd1);
        check("post_rst_iaddr", iaddr, PC_INIT);
        check("post_rst_valid", 32'(fd_valid), 32'd0);
    endtask

    initial begin
        word_t a;
        int    halted_for;
        model_reset();
        @(posedge CLK); #1;
        do_reset();

        // sequential hits from 0x0
        for (int k = 0; k < 3; k++) begin
            a = 32'(k * 4);
            check("seq_iaddr", iaddr, a);
            step(1, instr_at(a), 0, 0, '0, 0);
            check("seq_npc", fd_npc, a + 32'd4);
            check("seq_instr", fd_instr, instr_at(a));
            check("seq_valid", 32'(fd_valid), 32'd1);
        end
        step(1, instr_at(32'hC), 0, 0, '0, 0);

        // miss at 0x10 for three cycles
        for (int k = 0; k < 3; k++) begin
            step(0, 32'hBAD0_BAD0, 0, 0, '0, 0);
            check("miss_iaddr", iaddr, 32'h10);
            check("miss_valid", 32'(fd_valid), 32'd0);
        end
        step(1, 32'h1234_5678, 0, 0, '0, 0);
        check("miss_done_instr", fd_instr, 32'h1234_5678);
        check("miss_done_npc", fd_npc, 32'h14);

        for (int k = 0; k < 3; k++) step(1, instr_at(32'h14 + 32'(k * 4)), 0, 0, '0, 0);

        // stall with ihit at 0x20
        for (int k = 0; k < 2; k++) begin
            step(1, 32'h5555_AAAA, 1, 0, '0, 0);
            check("stall_npc", fd_npc, 32'h20);
            check("stall_instr", fd_instr, instr_at(32'h1C));
            check("stall_iaddr", iaddr, 32'h20);
        end
        step(1, instr_at(32'h20), 0, 0, '0, 0);
        check("stall_rel_npc", fd_npc, 32'h24);

        for (int k = 0; k < 7; k++) step(1, instr_at(32'h24 + 32'(k * 4)), 0, 0, '0, 0);

        // redirect to 0x103 during a miss at 0x40
        check("pre_redir_iaddr", iaddr, 32'h40);
        step(0, '0, 0, 1, 32'h103, 0);
        check("drain_iaddr0", iaddr, 32'h40);
        check("drain_valid0", 32'(fd_valid), 32'd0);
        for (int k = 0; k < 2; k++) begin
            step(0, '0, 0, 0, '0, 0);
            check("drain_iaddr", iaddr, 32'h40);
        end
        step(1, 32'hDEAD_BEEF, 0, 0, '0, 0);
        check("drain_target", iaddr, 32'h100);
        check("drain_drop", 32'(fd_valid), 32'd0);

        // two redirects while draining: latest wins
        step(0, '0, 0, 1, 32'h180, 0);
        step(0, '0, 0, 1, 32'h200, 0);
        step(1, 32'hDEAD_BEEF, 0, 0, '0, 0);
        check("latest_target", iaddr, 32'h200);
        step(1, instr_at(32'h200), 0, 0, '0, 0);
        check("after_target_npc", fd_npc, 32'h204);

        // redirect with hit to top of memory, then wrap
        step(1, 32'hDEAD_BEEF, 0, 1, 32'hFFFF_FFFE, 0);
        check("top_iaddr", iaddr, 32'hFFFF_FFFC);
        check("top_flush", 32'(fd_valid), 32'd0);
        step(1, 32'h0BAD_F00D, 0, 0, '0, 0);
        check("wrap_npc", fd_npc, 32'h0);
        check("wrap_iaddr", iaddr, 32'h0);

        // halt with hit
        step(1, 32'h1111_2222, 0, 0, '0, 1);
        check("halt_iren", 32'(iREN), 32'd0);
        for (int k = 0; k < 5; k++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            check("halted_iren", 32'(iREN), 32'd0);
            check("halted_valid", 32'(fd_valid), 32'd0);
            check("halted_iaddr", iaddr, 32'h0);
        end
        do_reset();

        // randomized traffic against the model
        halted_for = 0;
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 99) < 60), $urandom,
                 1'($urandom_range(0, 99) < 25),
                 1'($urandom_range(0, 99) < 10), $urandom,
                 1'($urandom_range(0, 99) < 3));
            halted_for = (m_mode == MH) ? halted_for + 1 : 0;
            if (halted_for > 3 || $urandom_range(0, 99) == 0) begin
                do_reset();
                halted_for = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
